// File: rtl/reg4_piso_tx_pkg.sv
// Shared definitions for the 4-bit register-bank serial transmit path.
// The receive-side capture block uses the same word width and counter sizing.
package reg4_piso_tx_pkg;

    // Default word width, shared with the matching serial-receive block.
    localparam int REG4_WIDTH = 4;

    // Transmitter control states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Bits needed to index every bit of a w-bit word (at least 1).
    function automatic int cnt_width(input int w);
        int r;
        r = 1;
        for (int k = 1; k < 32; k++) begin
            if ((1 << k) < w) begin
                r = k + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reg4_piso_tx_shift_core.sv
// Shift register plus bit counter for the serial transmitter.
// The register holds the bits not yet presented, so the bit to present next
// is always at the head: bit 0 when LSB_FIRST=1, bit WIDTH-1 otherwise.
module reg4_shift_core
    import reg4_piso_tx_pkg::*;
#(
    parameter int WIDTH     = REG4_WIDTH,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             nxt_bit,
    output logic             last,
    output logic             pen
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;

    // Drop the head bit, moving the following bit into the head position.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
        if (LSB_FIRST != 0) begin
            return v >> 1;
        end
        return v << 1;
    endfunction

    // Bit that goes out first from a word.
    function automatic logic head(input logic [WIDTH-1:0] v);
        if (LSB_FIRST != 0) begin
            return v[0];
        end
        return v[WIDTH-1];
    endfunction

    // Load keeps the remainder of the new word; shift consumes one more bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= shift_once(din);
            cnt <= '0;
        end else if (shift) begin
            sr  <= shift_once(sr);
            cnt <= cnt + 1'b1;
        end
    end

    // On load the first bit comes straight from the input word.
    assign nxt_bit = load ? head(din) : head(sr);
    // cnt indexes the bit currently on the serial output.
    assign last    = (cnt == CW'(WIDTH - 1));
    assign pen     = (cnt == CW'(WIDTH - 2));

endmodule

// File: rtl/reg4_piso_tx.sv
// Parallel-in serial-out transmitter with first/last framing markers.
// A word accepted on ld&&rdy appears on so starting the next cycle, one bit
// per clock; a new word may be accepted on the last-bit cycle so that
// consecutive words stream with no idle gap.
// Handshake: a word on i is taken at a rising edge of cl where ld=1 and
// rdy=1; ld with rdy=0 is ignored. so is meaningful only while sv=1, and
// frm/lst mark the first/last bit of each word only while sv=1.
module reg4_piso_tx
    import reg4_piso_tx_pkg::*;
#(
    parameter int WIDTH     = REG4_WIDTH,
    parameter int LSB_FIRST = 1
) (
    input  logic             cl,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i,
    input  logic             ld,
    output logic             rdy,
    output logic             so,
    output logic             sv,
    output logic             frm,
    output logic             lst
);

    state_t state;
    state_t state_nxt;
    logic   load;
    logic   shift;
    logic   nxt_bit;
    logic   last;
    logic   pen;

    reg4_shift_core #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_core (
        .clk     (cl),
        .rst_n   (rst_n),
        .load    (load),
        .shift   (shift),
        .din     (i),
        .nxt_bit (nxt_bit),
        .last    (last),
        .pen     (pen)
    );

    // State register.
    always_ff @(posedge cl or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake and shift-core controls.
    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            ST_IDLE: begin
                rdy = 1'b1;
                if (ld) begin
                    load      = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!last) begin
                    shift = 1'b1;
                end else begin
                    rdy = 1'b1;
                    if (ld) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered serial outputs; so keeps its value once the stream stops.
    always_ff @(posedge cl or negedge rst_n) begin
        if (!rst_n) begin
            so  <= 1'b0;
            sv  <= 1'b0;
            frm <= 1'b0;
            lst <= 1'b0;
        end else if (load || shift) begin
            so  <= nxt_bit;
            sv  <= 1'b1;
            frm <= load;
            lst <= shift && pen;
        end else begin
            sv  <= 1'b0;
            frm <= 1'b0;
            lst <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg4_piso_tx.sv
// Bench for reg4_piso_tx: an LSB-first and an MSB-first instance.
module tb_reg4_piso_tx;

    localparam int W = 4;

    logic         cl = 1'b0;
    logic         rst_n;
    logic [W-1:0] i;
    logic         ld;
    logic [W-1:0] i_m;
    logic         ld_m;
    logic         rdy, so, sv, frm, lst;
    logic         rdy_m, so_m, sv_m, frm_m, lst_m;

    int n_checks = 0;
    int n_pass   = 0;

    // Entries are {frm, lst, so}.
    logic [2:0] exp_q[$];
    logic [2:0] exp_m_q[$];

    // Clock.
    always #5 cl = ~cl;

    reg4_piso_tx #(.WIDTH(W), .LSB_FIRST(1)) dut_l (
        .cl (cl), .rst_n (rst_n), .i (i), .ld (ld),
        .rdy (rdy), .so (so), .sv (sv), .frm (frm), .lst (lst)
    );

    reg4_piso_tx #(.WIDTH(W), .LSB_FIRST(0)) dut_m (
        .cl (cl), .rst_n (rst_n), .i (i_m), .ld (ld_m),
        .rdy (rdy_m), .so (so_m), .sv (sv_m), .frm (frm_m), .lst (lst_m)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // seq lists the serial bits in transmit order, left to right.
    task automatic push_seq(input logic [3:0] seq, input bit msb_dut);
        logic [2:0] e;
        for (int k = 0; k < 4; k++) begin
            e = {(k == 0), (k == 3), seq[3-k]};
            if (msb_dut) exp_m_q.push_back(e);
            else         exp_q.push_back(e);
        end
    endtask

    // Monitor for the LSB-first instance.
    always @(negedge cl) begin
        logic [2:0] e;
        if (rst_n) begin
            if (sv) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL lsb_unexpected_bit: got so=%0b frm=%0b lst=%0b expected no bit at %0t",
                             so, frm, lst, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("lsb_stream", {29'd0, frm, lst, so}, {29'd0, e});
                end
            end else begin
                chk("lsb_idle_flags", {30'd0, frm, lst}, 32'd0);
            end
        end
    end

    // Monitor for the MSB-first instance.
    always @(negedge cl) begin
        logic [2:0] e;
        if (rst_n) begin
            if (sv_m) begin
                if (exp_m_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL msb_unexpected_bit: got so=%0b frm=%0b lst=%0b expected no bit at %0t",
                             so_m, frm_m, lst_m, $time);
                end else begin
                    e = exp_m_q.pop_front();
                    chk("msb_stream", {29'd0, frm_m, lst_m, so_m}, {29'd0, e});
                end
            end else begin
                chk("msb_idle_flags", {30'd0, frm_m, lst_m}, 32'd0);
            end
        end
    end

    // Stimulus.
    initial begin
        rst_n = 1'b0;
        ld    = 1'b0;
        ld_m  = 1'b0;
        i     = '0;
        i_m   = '0;
        repeat (2) @(negedge cl);
        chk("rst_so", so, 0);
        chk("rst_sv", sv, 0);
        chk("rst_frm", frm, 0);
        chk("rst_lst", lst, 0);
        chk("rst_rdy", rdy, 1);
        chk("rst_m_sv", sv_m, 0);
        chk("rst_m_rdy", rdy_m, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge cl);
        chk("idle_no_bits", sv, 0);

        // Single word, LSB first.
        i = 4'b1011; ld = 1'b1; push_seq(4'b1101, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge cl);
            ld = 1'b0;
            chk("t1_sv", sv, 1);
            chk("t1_rdy", rdy, (c == 4));
        end
        @(negedge cl);
        chk("t1_sv_after", sv, 0);

        // Back-to-back words.
        i = 4'b0110; ld = 1'b1; push_seq(4'b0110, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge cl);
            chk("t2_sv", sv, 1);
            chk("t2_rdy", rdy, (c == 4 || c == 8));
            if (c == 4) begin
                i = 4'b1001; ld = 1'b1; push_seq(4'b1001, 1'b0);
            end else begin
                ld = 1'b0;
            end
        end
        @(negedge cl);
        chk("t2_sv_after", sv, 0);

        // Load request while busy is ignored.
        i = 4'b1111; ld = 1'b1; push_seq(4'b1111, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge cl);
            if (c == 2) begin
                chk("t3_rdy_busy", rdy, 0);
                i = 4'b0000; ld = 1'b1;
            end else begin
                ld = 1'b0;
            end
        end
        @(negedge cl);
        chk("t3_sv_after", sv, 0);
        @(negedge cl);
        chk("t3_sv_idle", sv, 0);

        // Input changes during shifting do not affect the word in flight.
        i = 4'b1010; ld = 1'b1; push_seq(4'b0101, 1'b0);
        @(negedge cl);
        ld = 1'b0; i = 4'b0101;
        repeat (4) @(negedge cl);
        chk("t4_sv_after", sv, 0);

        // Reset in the middle of a word.
        i = 4'b1100; ld = 1'b1;
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b000);
        @(negedge cl);
        ld = 1'b0;
        @(negedge cl);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_so", so, 0);
        chk("t5_sv", sv, 0);
        chk("t5_frm", frm, 0);
        chk("t5_lst", lst, 0);
        chk("t5_rdy", rdy, 1);
        @(negedge cl);
        rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge cl);
            chk("t5_sv_after_release", sv, 0);
        end

        // MSB-first instance.
        i_m = 4'b1011; ld_m = 1'b1; push_seq(4'b1011, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge cl);
            ld_m = 1'b0;
            chk("t6_sv", sv_m, 1);
            chk("t6_rdy", rdy_m, (c == 4));
        end
        @(negedge cl);
        chk("t6_sv_after", sv_m, 0);

        repeat (2) @(negedge cl);
        chk("lsb_queue_empty", exp_q.size(), 0);
        chk("msb_queue_empty", exp_m_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
